// File: rtl/pwm_pkg.sv
// Shared constants, stager state and register-address decode for the PWM update scheduler.
package pwm_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 4;

    localparam logic [7:0] ADDR_PERIOD_LO = 8'h10;
    localparam logic [7:0] ADDR_PERIOD_HI = 8'h11;
    localparam logic [7:0] ADDR_CTRL      = 8'h12;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_FORCE_BIT = 1;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_LO_HELD = 1'b1
    } stager_state_e;

    // Decoded view of a byte address into a 16-bit register entry
    typedef struct packed {
        logic             hit;
        logic             hi;
        logic [IDX_W-1:0] idx;
    } reg_dec_t;

    // Duty entries occupy 0..2*num_ch-1; the period entry sits after the last channel
    function automatic reg_dec_t decode_addr(input logic [7:0] addr, input int unsigned num_ch);
        reg_dec_t d;
        d.hit = 1'b0;
        d.hi  = addr[0];
        d.idx = '0;
        if (32'(addr) < 2 * num_ch) begin
            d.hit = 1'b1;
            d.idx = IDX_W'(addr[7:1]);
        end else if (addr == ADDR_PERIOD_LO || addr == ADDR_PERIOD_HI) begin
            d.hit = 1'b1;
            d.idx = IDX_W'(num_ch);
        end
        return d;
    endfunction

endpackage

// File: rtl/pwm_compare.sv
// One PWM channel: compares the shared counter against this channel's active duty.
module pwm_compare #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             Clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] counter,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm
);

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= enable && (counter < duty);
        end
    end

endmodule

// File: rtl/pwm_update_scheduler.sv
// PWM timebase and duty/period registers; byte-pair writes land in shadows and are
// committed to the active set only at period boundaries (or on a forced commit).
module pwm_update_scheduler
    import pwm_pkg::*;
#(
    parameter int unsigned      NUM_CH     = 8,
    parameter int unsigned      CNT_W      = 16,
    parameter logic [CNT_W-1:0] PERIOD_RST = CNT_W'(16'hFFFF)
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        rd_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic              commit_pending
);

    localparam int unsigned NUM_ENT = NUM_CH + 1;
    localparam int unsigned PER_IDX = NUM_CH;

    logic [CNT_W-1:0]   shadow_q [NUM_ENT];
    logic [CNT_W-1:0]   active_q [NUM_ENT];
    logic [NUM_ENT-1:0] dirty_q;
    logic [NUM_ENT-1:0] dirty_d;
    logic [NUM_ENT-1:0] set_mask;

    stager_state_e      stg_state_q;
    logic [IDX_W-1:0]   held_idx_q;
    logic [BYTE_W-1:0]  hold_q;

    logic [CNT_W-1:0]   counter_q;
    logic               enable_q;
    logic               enable_d;

    reg_dec_t           dec;
    logic               lo_wr;
    logic               hi_wr;
    logic               pair_match;
    logic [CNT_W-1:0]   hi_value;
    logic               ctrl_wr;
    logic               force_commit;
    logic [CNT_W-1:0]   period_active;
    logic               wrap;
    logic               boundary;
    logic [CNT_W-1:0]   rd_entry;

    assign dec        = decode_addr(wr_addr, NUM_CH);
    assign lo_wr      = wr_en && dec.hit && !dec.hi;
    assign hi_wr      = wr_en && dec.hit && dec.hi;
    assign pair_match = (stg_state_q == S_LO_HELD) && (held_idx_q == dec.idx);

    // An orphan high byte keeps the shadow's existing low byte
    assign hi_value = pair_match ? CNT_W'({wr_data, hold_q})
                                 : CNT_W'({wr_data, shadow_q[dec.idx][BYTE_W-1:0]});

    assign ctrl_wr       = wr_en && (wr_addr == ADDR_CTRL);
    assign force_commit  = ctrl_wr && wr_data[CTRL_FORCE_BIT];
    assign enable_d      = ctrl_wr ? wr_data[CTRL_EN_BIT] : enable_q;
    assign period_active = active_q[PER_IDX];
    assign wrap          = enable_q && (counter_q == period_active);
    assign boundary      = wrap || !enable_q || force_commit;

    // A write landing on a boundary re-marks its entry dirty after the clear
    assign set_mask = hi_wr ? (NUM_ENT'(1) << dec.idx) : '0;
    assign dirty_d  = (boundary ? '0 : dirty_q) | set_mask;

    // Byte-pair stager
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_state_q <= S_IDLE;
            held_idx_q  <= '0;
            hold_q      <= '0;
        end else if (lo_wr) begin
            stg_state_q <= S_LO_HELD;
            held_idx_q  <= dec.idx;
            hold_q      <= wr_data;
        end else if (hi_wr && pair_match) begin
            stg_state_q <= S_IDLE;
        end
    end

    // Shadow, active and dirty register files
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ENT; i++) begin
                shadow_q[i] <= (i == PER_IDX) ? PERIOD_RST : '0;
                active_q[i] <= (i == PER_IDX) ? PERIOD_RST : '0;
            end
            dirty_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_ENT; i++) begin
                if (boundary && dirty_q[i]) begin
                    active_q[i] <= shadow_q[i];
                end
            end
            if (hi_wr) begin
                shadow_q[dec.idx] <= hi_value;
            end
            dirty_q <= dirty_d;
        end
    end

    // Timebase, control and status flags
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            counter_q      <= '0;
            enable_q       <= 1'b0;
            period_start   <= 1'b0;
            commit_pending <= 1'b0;
        end else begin
            counter_q      <= (!enable_q || wrap) ? '0 : counter_q + CNT_W'(1);
            enable_q       <= enable_d;
            period_start   <= wrap && enable_d;
            commit_pending <= |dirty_d;
        end
    end

    always_comb begin
        rd_data  = '0;
        rd_entry = shadow_q[dec.idx];
        if (dec.hit) begin
            rd_data = dec.hi ? rd_entry[2*BYTE_W-1:BYTE_W] : rd_entry[BYTE_W-1:0];
        end else if (wr_addr == ADDR_CTRL) begin
            rd_data = {6'b0, commit_pending, enable_q};
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_compare #(
            .CNT_W (CNT_W)
        ) u_cmp (
            .Clk     (Clk),
            .rst_n   (rst_n),
            .enable  (enable_q),
            .counter (counter_q),
            .duty    (active_q[g]),
            .pwm     (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Directed bench for pwm_update_scheduler: stimulus queues expectations, a negedge monitor checks them.
module tb_pwm_update_scheduler;

    logic       Clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic [7:0] pwm_out;
    logic       period_start;
    logic       commit_pending;

    pwm_update_scheduler dut (
        .Clk            (Clk),
        .rst_n          (rst_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .rd_data        (rd_data),
        .pwm_out        (pwm_out),
        .period_start   (period_start),
        .commit_pending (commit_pending)
    );

    always #5 Clk = ~Clk;

    typedef enum {K_RD, K_PWM, K_PS, K_CP} kind_e;
    typedef struct {
        int         cyc;
        kind_e      kind;
        logic [7:0] exp;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    int    E = 0;
    int    prev_d[8] = '{default: 0};
    int    cur_d[8]  = '{default: 0};

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: pop every expectation stamped for this cycle and compare
    always @(negedge Clk) begin
        exp_t       e;
        string      n;
        logic [7:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n = sb_name.pop_front();
            case (e.kind)
                K_RD:    act = rd_data;
                K_PWM:   act = pwm_out;
                K_PS:    act = {7'b0, period_start};
                default: act = {7'b0, commit_pending};
            endcase
            checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                errors++;
                $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic chk(input kind_e k, input logic [7:0] v, input string n);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.exp  = v;
        sb.push_back(e);
        sb_name.push_back(n);
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] v, input string n);
        wr_addr = a;
        chk(K_RD, v, n);
    endtask

    task automatic goto_cnt(input int k);
        for (int i = 0; i < 10 && ((cyc - E) % 10) != k; i++) tick();
    endtask

    // Checks one full 10-cycle period starting at counter 0 (period = 9)
    task automatic check_period(input logic exp_cp);
        logic [7:0] v;
        for (int k = 0; k < 10; k++) begin
            for (int ch = 0; ch < 8; ch++)
                v[ch] = (k == 0) ? (9 < prev_d[ch]) : ((k - 1) < cur_d[ch]);
            chk(K_PWM, v, "pwm_period");
            chk(K_PS, {7'b0, k == 0}, "period_start");
            if (k == 0) chk(K_CP, {7'b0, exp_cp}, "cp_at_boundary");
            tick();
        end
        for (int ch = 0; ch < 8; ch++) prev_d[ch] = cur_d[ch];
    endtask

    initial begin
        // Reset state
        tick();
        rd_chk(8'h10, 8'hFF, "rst_period_lo");
        chk(K_PWM, 8'h00, "rst_pwm");
        chk(K_CP, 8'h00, "rst_cp");
        chk(K_PS, 8'h00, "rst_ps");
        tick();
        rd_chk(8'h11, 8'hFF, "rst_period_hi");
        rst_n = 1'b1;
        tick();
        rd_chk(8'h12, 8'h00, "rst_ctrl");
        tick();

        // Period 9 commits while disabled, then enable
        wr(8'h10, 8'h09);
        wr(8'h11, 8'h00);
        wr(8'h12, 8'h01);
        E = cyc;
        chk(K_PS, 8'h00, "no_ps_on_enable");
        wr(8'h00, 8'h03);
        wr(8'h01, 8'h00);
        chk(K_CP, 8'h01, "cp_after_duty0");

        // Duty1 low byte at counter 2, high byte on the boundary cycle
        wr(8'h02, 8'h05);
        goto_cnt(9);
        chk(K_CP, 8'h01, "cp_before_boundary");
        wr(8'h03, 8'h00);
        cur_d[0] = 3;
        check_period(1'b1);
        cur_d[1] = 5;
        check_period(1'b0);

        // Orphan high byte, held low byte survives for channel 3, duty 0 / above-period
        wr(8'h04, 8'h34);
        wr(8'h06, 8'h56);
        wr(8'h05, 8'h12);
        wr(8'h07, 8'h00);
        wr(8'h08, 8'h00);
        wr(8'h09, 8'h00);
        wr(8'h0A, 8'h0A);
        wr(8'h0B, 8'h00);
        chk(K_CP, 8'h01, "cp_batch");
        rd_chk(8'h04, 8'h00, "shadow2_lo");
        tick();
        rd_chk(8'h05, 8'h12, "shadow2_hi");
        tick();
        cur_d[2] = 32'h1200;
        cur_d[3] = 32'h56;
        cur_d[4] = 0;
        cur_d[5] = 10;
        check_period(1'b0);

        rd_chk(8'h06, 8'h56, "shadow3_lo"); tick();
        rd_chk(8'h07, 8'h00, "shadow3_hi"); tick();
        rd_chk(8'h0A, 8'h0A, "shadow5_lo"); tick();
        rd_chk(8'h0B, 8'h00, "shadow5_hi"); tick();
        rd_chk(8'h02, 8'h05, "shadow1_lo"); tick();
        rd_chk(8'h03, 8'h00, "shadow1_hi"); tick();
        rd_chk(8'h10, 8'h09, "period_lo");  tick();
        rd_chk(8'h11, 8'h00, "period_hi");  tick();
        rd_chk(8'h13, 8'h00, "unmapped");   tick();
        rd_chk(8'h12, 8'h01, "ctrl_idle");  tick();

        // Period 0xFFFF and duty0 0x0100, forced commit mid-period
        goto_cnt(0);
        wr(8'h10, 8'hFF);
        wr(8'h11, 8'hFF);
        wr(8'h00, 8'h00);
        wr(8'h01, 8'h01);
        chk(K_CP, 8'h01, "cp_before_force");
        wr(8'h12, 8'h03);
        rd_chk(8'h12, 8'h01, "ctrl_after_force");
        chk(K_CP, 8'h00, "cp_after_force");
        chk(K_PWM, 8'h2E, "pwm_force_edge");
        tick();
        chk(K_PWM, 8'h2D, "pwm_after_force");
        tick(); tick(); tick(); tick();
        chk(K_PS, 8'h00, "no_wrap_at_10");
        chk(K_PWM, 8'h2D, "pwm_cnt9");
        tick();
        chk(K_PWM, 8'h0D, "pwm_cnt10");
        wr(8'h09, 8'h00);

        // Asynchronous reset mid-period
        rst_n = 1'b0;
        #1;
        chk(K_PWM, 8'h00, "async_rst_pwm");
        chk(K_PS, 8'h00, "async_rst_ps");
        chk(K_CP, 8'h00, "async_rst_cp");
        rd_chk(8'h01, 8'h00, "async_rst_duty0_hi");
        tick();
        rd_chk(8'h12, 8'h00, "async_rst_ctrl");
        tick();
        rd_chk(8'h10, 8'hFF, "async_rst_period");
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
